// File: rtl/puzzle_move_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : puzzle_move_ctrl
// Description : LOAD/MOVE/COMMIT sequencer for the 8-puzzle register file.
//               Optional macro NO_BACKTRACK_EN rejects moves that undo the last.
// Revision    : 1.0 - initial release
// ============================================================================
module puzzle_move_ctrl #(
    parameter logic [3:0] INIT_ADDR      = 4'd0,
    parameter logic [3:0] TEMP_ADDR      = 4'd2,
    parameter logic [3:0] DIRECTION_ADDR = 4'd3,
    parameter logic [3:0] TEMP_DIR_ADDR  = 4'd4,
    parameter int         MAX_DEPTH      = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [1:0]  cmd_dir,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [1:0]  rsp_err,
    output logic [3:0]  rsp_depth,
    output logic        rsp_solved,
    output logic [3:0]  src0,
    output logic [3:0]  src1,
    output logic [3:0]  dst,
    output logic        we,
    output logic [39:0] data,
    input  logic [39:0] data0,
    input  logic [39:0] data1,
    input  logic        comp
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_WB   = 3'd2,
        S_WD   = 3'd3,
        S_RESP = 3'd4
    } state_t;

    localparam logic [1:0] c_OP_LOAD   = 2'b00;
    localparam logic [1:0] c_OP_MOVE   = 2'b01;
    localparam logic [1:0] c_OP_COMMIT = 2'b10;
    localparam logic [4:0] c_MAX_DEPTH = 5'(MAX_DEPTH);

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_op;
    logic [1:0]  r_dir;
    logic [39:0] r_board;
    logic [33:0] r_hist;
    logic [1:0]  r_err;
    logic [3:0]  r_depth;

    logic [3:0]  w_p;
    logic [3:0]  w_d;
    logic [1:0]  w_err;
    logic [3:0]  w_depth;
    logic [3:0]  w_rp;
    logic [3:0]  w_t;
    logic [3:0]  w_tcell;
    logic [39:0] w_new_board;
    logic [39:0] w_new_hist;
    logic        w_unused;

    function automatic logic [3:0] f_target(input logic [3:0] p, input logic [1:0] dir);
        case (dir)
            2'b00:   f_target = p - 4'd3;
            2'b01:   f_target = p + 4'd3;
            2'b10:   f_target = p - 4'd1;
            default: f_target = p + 4'd1;
        endcase
    endfunction

    function automatic logic f_legal(input logic [3:0] p, input logic [1:0] dir);
        case (dir)
            2'b00:   f_legal = (p >= 4'd3);
            2'b01:   f_legal = (p <= 4'd5);
            2'b10:   f_legal = !((p == 4'd0) || (p == 4'd3) || (p == 4'd6));
            default: f_legal = !((p == 4'd2) || (p == 4'd5) || (p == 4'd8));
        endcase
    endfunction

    assign w_p      = data0[39:36];
    assign w_d      = data1[33:30];
    assign w_unused = &{1'b0, data1[39:34]};

    // Legality is judged on the live read data while in READ, then registered.
    always_comb begin
`ifdef NO_BACKTRACK_EN
        logic [1:0] v_prev;
        v_prev = 2'b00;
        for (int i = 1; i < 16; i++) begin
            if (w_d == 4'(i)) v_prev = data1[2*i-1 -: 2];
        end
`endif
        w_err   = 2'b00;
        w_depth = w_d;
        case (r_op)
            c_OP_LOAD: begin
                if (w_p > 4'd8) w_err = 2'b11;
                else            w_depth = 4'd0;
            end
            c_OP_MOVE: begin
                if (w_p > 4'd8)                         w_err = 2'b11;
                else if ({1'b0, w_d} >= c_MAX_DEPTH)    w_err = 2'b10;
`ifdef NO_BACKTRACK_EN
                else if ((w_d != 4'd0) && (r_dir == (v_prev ^ 2'b01))) w_err = 2'b11;
`endif
                else if (!f_legal(w_p, r_dir))          w_err = 2'b01;
                else                                    w_depth = w_d + 4'd1;
            end
            c_OP_COMMIT: w_err = 2'b00;
            default:     w_err = 2'b11;
        endcase
    end

    // Slide: blank cell takes the target tile, target cell becomes blank.
    always_comb begin
        w_rp    = r_board[39:36];
        w_t     = f_target(w_rp, r_dir);
        w_tcell = 4'd0;
        for (int k = 0; k < 9; k++) begin
            if (w_t == 4'(k)) w_tcell = r_board[35-4*k -: 4];
        end
        w_new_board        = r_board;
        w_new_board[39:36] = w_t;
        for (int k = 0; k < 9; k++) begin
            if (w_rp == 4'(k)) w_new_board[35-4*k -: 4] = w_tcell;
            if (w_t  == 4'(k)) w_new_board[35-4*k -: 4] = 4'd0;
        end
    end

    always_comb begin
        w_new_hist        = {6'b0, r_hist};
        w_new_hist[33:30] = r_hist[33:30] + 4'd1;
        for (int i = 0; i < 15; i++) begin
            if (r_hist[33:30] == 4'(i)) w_new_hist[2*i+1 -: 2] = r_dir;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_op    <= 2'b00;
            r_dir   <= 2'b00;
            r_board <= 40'd0;
            r_hist  <= 34'd0;
            r_err   <= 2'b00;
            r_depth <= 4'd0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && cmd_valid) begin
                r_op  <= cmd_op;
                r_dir <= cmd_dir;
            end
            if (r_state == S_READ) begin
                r_board <= data0;
                r_hist  <= data1[33:0];
                r_err   <= w_err;
                r_depth <= w_depth;
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        src0      = TEMP_ADDR;
        src1      = TEMP_DIR_ADDR;
        dst       = TEMP_ADDR;
        we        = 1'b0;
        data      = 40'd0;
        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) w_next = S_READ;
            end
            S_READ: begin
                if (r_op == c_OP_LOAD) src0 = INIT_ADDR;
                w_next = S_WB;
            end
            S_WB: begin
                if (r_err != 2'b00) begin
                    w_next = S_RESP;
                end else begin
                    we = 1'b1;
                    case (r_op)
                        c_OP_LOAD: begin
                            data   = r_board;
                            w_next = S_WD;
                        end
                        c_OP_MOVE: begin
                            data   = w_new_board;
                            w_next = S_WD;
                        end
                        c_OP_COMMIT: begin
                            dst    = DIRECTION_ADDR;
                            data   = {6'b0, r_hist};
                            w_next = S_RESP;
                        end
                        default: begin
                            we     = 1'b0;
                            w_next = S_RESP;
                        end
                    endcase
                end
            end
            S_WD: begin
                we     = 1'b1;
                dst    = TEMP_DIR_ADDR;
                data   = (r_op == c_OP_MOVE) ? w_new_hist : 40'd0;
                w_next = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign rsp_err    = r_err;
    assign rsp_depth  = r_depth;
    assign rsp_solved = (r_state == S_RESP) && comp;

endmodule
`default_nettype wire

// File: tb/tb_puzzle_move_ctrl.sv
`default_nettype none
// Directed bench for puzzle_move_ctrl with a behavioural 16x40 register file.
module tb_puzzle_move_ctrl;

    localparam logic [39:0] c_START  = 40'h0052143786;
    localparam logic [39:0] c_SOLVED = 40'h8123456780;
    localparam logic [1:0]  c_UP = 2'b00, c_DOWN = 2'b01, c_LEFT = 2'b10, c_RIGHT = 2'b11;
    localparam logic [1:0]  c_LOAD = 2'b00, c_MOVE = 2'b01, c_COMMIT = 2'b10, c_RSV = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [1:0]  cmd_dir = 2'b00;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [1:0]  rsp_err;
    logic [3:0]  rsp_depth;
    logic        rsp_solved;
    logic [3:0]  src0, src1, dst;
    logic        we;
    logic [39:0] data, data0, data1;
    logic        comp;

    logic [39:0] rf [16];
    logic        tb_wr = 1'b0;
    logic [3:0]  tb_addr = 4'd0;
    logic [39:0] tb_data = 40'd0;

    int errors = 0;
    int checks = 0;
    logic [1:0] g_err;
    logic [3:0] g_depth;
    logic       g_solved;
    int         g_lat;
    int         g_we;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (we)         rf[dst]     <= data;
        else if (tb_wr) rf[tb_addr] <= tb_data;
    end
    assign data0 = rf[src0];
    assign data1 = rf[src1];
    assign comp  = (rf[2] == c_SOLVED);

    puzzle_move_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_dir(cmd_dir),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_err(rsp_err),
        .rsp_depth(rsp_depth), .rsp_solved(rsp_solved),
        .src0(src0), .src1(src1), .dst(dst), .we(we), .data(data),
        .data0(data0), .data1(data1), .comp(comp)
    );

    task automatic poke(input logic [3:0] a, input logic [39:0] v);
        @(negedge clk);
        tb_wr = 1'b1; tb_addr = a; tb_data = v;
        @(posedge clk);
        #1 tb_wr = 1'b0;
    endtask

    // Issue one command and wait (bounded) for the response; no acknowledge.
    task automatic run_cmd(input logic [1:0] op, input logic [1:0] dir);
        @(negedge clk);
        cmd_op = op; cmd_dir = dir; cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        g_lat = 1; g_we = 0;
        while (!rsp_valid && g_lat < 20) begin
            if (we) g_we++;
            @(negedge clk);
            g_lat++;
        end
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++; $display("FAIL rsp_timeout op=%0d got rsp_valid=%b want 1", op, rsp_valid);
        end
        g_err = rsp_err; g_depth = rsp_depth; g_solved = rsp_solved;
    endtask

    task automatic ack();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [1:0] dir);
        run_cmd(op, dir);
        ack();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (we !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", we); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
        checks++;
        if ({src0, src1, dst} !== {4'd2, 4'd4, 4'd2}) begin
            errors++; $display("FAIL reset_addr got src0=%0d src1=%0d dst=%0d want 2 4 2", src0, src1, dst);
        end
        checks++;
        if ({data, rsp_err, rsp_depth, rsp_solved} !== 47'd0) begin
            errors++; $display("FAIL reset_outs got data=%h err=%0d depth=%0d solved=%b want 0", data, rsp_err, rsp_depth, rsp_solved);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_load();
        poke(4'd0, c_START);
        poke(4'd2, 40'hFFFFFFFFFF);
        poke(4'd4, 40'h0000012345);
        do_cmd(c_LOAD, c_UP);
        checks++; if (g_lat != 4) begin errors++; $display("FAIL load_latency got %0d want 4", g_lat); end
        checks++; if (g_we != 2) begin errors++; $display("FAIL load_we_cycles got %0d want 2", g_we); end
        checks++;
        if ({g_err, g_depth, g_solved} !== 7'd0) begin
            errors++; $display("FAIL load_rsp got err=%0d depth=%0d solved=%b want 0 0 0", g_err, g_depth, g_solved);
        end
        checks++; if (rf[2] !== c_START) begin errors++; $display("FAIL load_temp got %h want %h", rf[2], c_START); end
        checks++; if (rf[4] !== 40'd0) begin errors++; $display("FAIL load_tempdir got %h want 0", rf[4]); end
    endtask

    task automatic test_move_right();
        do_cmd(c_LOAD, c_UP);
        do_cmd(c_MOVE, c_RIGHT);
        checks++; if (g_lat != 4) begin errors++; $display("FAIL move_latency got %0d want 4", g_lat); end
        checks++;
        if ({g_err, g_depth} !== {2'b00, 4'd1}) begin
            errors++; $display("FAIL move_rsp got err=%0d depth=%0d want 0 1", g_err, g_depth);
        end
        checks++; if (rf[2] !== 40'h1502143786) begin errors++; $display("FAIL move_temp got %h want 1502143786", rf[2]); end
        checks++; if (rf[4] !== 40'h0040000003) begin errors++; $display("FAIL move_tempdir got %h want 0040000003", rf[4]); end
    endtask

    task automatic test_move_edge();
        do_cmd(c_LOAD, c_UP);
        do_cmd(c_MOVE, c_UP);
        checks++; if (g_err !== 2'b01) begin errors++; $display("FAIL edge_err got %0d want 1", g_err); end
        checks++; if (g_lat != 3) begin errors++; $display("FAIL edge_latency got %0d want 3", g_lat); end
        checks++; if (g_we != 0) begin errors++; $display("FAIL edge_we got %0d want 0", g_we); end
        checks++; if (rf[2] !== c_START) begin errors++; $display("FAIL edge_temp got %h want %h", rf[2], c_START); end
        checks++; if (g_depth !== 4'd0) begin errors++; $display("FAIL edge_depth got %0d want 0", g_depth); end
    endtask

    task automatic test_solve_commit();
        logic [1:0] seq [6];
        int bad;
        seq = '{c_DOWN, c_RIGHT, c_UP, c_RIGHT, c_DOWN, c_DOWN};
        bad = 0;
        do_cmd(c_LOAD, c_UP);
        checks++; if (g_solved !== 1'b0) begin errors++; $display("FAIL load_unsolved got %b want 0", g_solved); end
        for (int i = 0; i < 6; i++) begin
            do_cmd(c_MOVE, seq[i]);
            if (g_err !== 2'b00) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL solve_errs got %0d errored moves want 0", bad); end
        checks++; if (rf[2] !== c_SOLVED) begin errors++; $display("FAIL solve_temp got %h want %h", rf[2], c_SOLVED); end
        checks++;
        if ({g_solved, g_depth} !== {1'b1, 4'd6}) begin
            errors++; $display("FAIL solve_rsp got solved=%b depth=%0d want 1 6", g_solved, g_depth);
        end
        do_cmd(c_COMMIT, c_UP);
        checks++; if (rf[3] !== 40'h01800005CD) begin errors++; $display("FAIL commit_dir got %h want 01800005cd", rf[3]); end
        checks++;
        if ({g_err, g_depth} !== {2'b00, 4'd6} || g_lat != 3) begin
            errors++; $display("FAIL commit_rsp got err=%0d depth=%0d lat=%0d want 0 6 3", g_err, g_depth, g_lat);
        end
    endtask

    task automatic test_bad_cmds();
        do_cmd(c_LOAD, c_UP);
        do_cmd(c_RSV, c_UP);
        checks++;
        if ({g_err, g_we, g_lat} !== {2'b11, 32'd0, 32'd3}) begin
            errors++; $display("FAIL reserved got err=%0d we=%0d lat=%0d want 3 0 3", g_err, g_we, g_lat);
        end
        poke(4'd0, 40'h9012345678);
        do_cmd(c_LOAD, c_UP);
        checks++;
        if ({g_err, g_we} !== {2'b11, 32'd0} || rf[2] !== c_START) begin
            errors++; $display("FAIL load_badp got err=%0d we=%0d temp=%h want 3 0 %h", g_err, g_we, rf[2], c_START);
        end
        poke(4'd0, c_START);
    endtask

    task automatic test_depth_full();
        int bad;
        logic [1:0] d;
        bad = 0;
        do_cmd(c_LOAD, c_UP);
        for (int i = 0; i < 15; i++) begin
`ifdef NO_BACKTRACK_EN
            case (i % 4)
                0: d = c_RIGHT;
                1: d = c_DOWN;
                2: d = c_LEFT;
                default: d = c_UP;
            endcase
`else
            d = (i % 2 == 0) ? c_RIGHT : c_LEFT;
`endif
            do_cmd(c_MOVE, d);
            if (g_err !== 2'b00) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL depth_fill_errs got %0d want 0", bad); end
        checks++;
        if (g_depth !== 4'd15 || rf[4][33:30] !== 4'd15) begin
            errors++; $display("FAIL depth_fill got rsp=%0d hist=%0d want 15 15", g_depth, rf[4][33:30]);
        end
        // 16th move also points off the board; depth error must win.
`ifdef NO_BACKTRACK_EN
        do_cmd(c_MOVE, c_LEFT);
`else
        do_cmd(c_MOVE, c_UP);
`endif
        checks++;
        if ({g_err, g_depth} !== {2'b10, 4'd15} || g_we != 0) begin
            errors++; $display("FAIL depth_full got err=%0d depth=%0d we=%0d want 2 15 0", g_err, g_depth, g_we);
        end
    endtask

    task automatic test_backtrack();
        do_cmd(c_LOAD, c_UP);
        do_cmd(c_MOVE, c_RIGHT);
        do_cmd(c_MOVE, c_LEFT);
        checks++;
`ifdef NO_BACKTRACK_EN
        if ({g_err, g_we} !== {2'b11, 32'd0} || rf[2] !== 40'h1502143786) begin
            errors++; $display("FAIL backtrack got err=%0d we=%0d temp=%h want 3 0 1502143786", g_err, g_we, rf[2]);
        end
`else
        if ({g_err, g_depth} !== {2'b00, 4'd2} || rf[2] !== c_START) begin
            errors++; $display("FAIL reversal got err=%0d depth=%0d temp=%h want 0 2 %h", g_err, g_depth, rf[2], c_START);
        end
`endif
    endtask

    task automatic test_stall();
        int bad;
        bad = 0;
        do_cmd(c_LOAD, c_UP);
        run_cmd(c_MOVE, c_RIGHT);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || rsp_err !== g_err ||
                rsp_depth !== g_depth || rsp_solved !== g_solved) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL stall_hold got %0d unstable cycles want 0", bad); end
        checks++; if (g_depth !== 4'd1) begin errors++; $display("FAIL stall_depth got %0d want 1", g_depth); end
        ack();
    endtask

    task automatic test_reset_wd();
        do_cmd(c_LOAD, c_UP);
        poke(4'd4, 40'h00000ABCDE);
        @(negedge clk);
        cmd_op = c_MOVE; cmd_dir = c_RIGHT; cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (we !== 1'b1 || dst !== 4'd4) begin errors++; $display("FAIL wd_reach got we=%b dst=%0d want 1 4", we, dst); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({we, rsp_valid, dst, data} !== {1'b0, 1'b0, 4'd2, 40'd0}) begin
            errors++; $display("FAIL reset_wd got we=%b rsp_valid=%b dst=%0d data=%h want 0 0 2 0", we, rsp_valid, dst, data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_wd_ready got %b want 1", cmd_ready); end
        checks++;
        if (rf[4] !== 40'h00000ABCDE || rf[2] !== 40'h1502143786) begin
            errors++; $display("FAIL reset_wd_rf got tempdir=%h temp=%h want 00000abcde 1502143786", rf[4], rf[2]);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rf[i] = 40'd0;
        test_reset();
        test_load();
        test_move_right();
        test_move_edge();
        test_solve_commit();
        test_bad_cmds();
        test_depth_full();
        test_backtrack();
        test_stall();
        test_reset_wd();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/puzzle_move_ctrl.md
Name: puzzle_move_ctrl

Overview:
- Sequencer for the 8-puzzle register file. Accepts board commands: LOAD, MOVE and COMMIT.
- Drives the register file's read ports (src0/src1) and its single write port (dst/we/data).
- Computes the slid board and appends the move to the move history.
- Reports legality, depth and the solved flag through a valid/ready response.

Parameters:
- INIT_ADDR, 0: register holding the start board
- TEMP_ADDR, 2: working board register
- DIRECTION_ADDR, 3: committed history register
- TEMP_DIR_ADDR, 4: working history register
- MAX_DEPTH, 15: maximum number of moves kept in history

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  2  00 LOAD, 01 MOVE, 10 COMMIT, 11 reserved
- cmd_dir  in  2  blank direction: 00 up, 01 down, 10 left, 11 right
- rsp_valid  out  1  response pending
- rsp_ready  in  1  response accepted
- rsp_err  out  2  00 ok, 01 edge, 10 history full, 11 bad state/backtrack
- rsp_depth  out  4  history depth after the command
- rsp_solved  out  1  comp sampled in RESP
- src0  out  4  register file read address 0
- src1  out  4  register file read address 1
- dst  out  4  register file write address
- we  out  1  register file write enable
- data  out  40  register file write data
- data0  in  40  register file read data 0
- data1  in  40  register file read data 1
- comp  in  1  register file solved flag

Behaviour:
- Board format:
  - [39:36] holds the blank position p (0..8).
  - Cell k (0..8, row-major) is at [35-4k:32-4k].
- History format:
  - [33:30] holds depth d.
  - Slot i is at [2i+1:2i].
  - [39:34] is written as 0.
- Reset (async, immediate):
  - State goes to IDLE; we=0; rsp_valid=0; rsp_err=0; rsp_depth=0; rsp_solved=0; data=0.
  - src0=TEMP_ADDR, src1=TEMP_DIR_ADDR, dst=TEMP_ADDR.
  - A command in flight is abandoned; no partial write continues after reset.
- States and transitions:
  - IDLE: cmd_ready=1. On cmd_valid, latch op/dir and go to READ.
  - READ (one cycle): capture data0/data1 into internal flops, evaluate legality, go to WB.
    - LOAD: src0=INIT_ADDR.
    - MOVE: src0=TEMP_ADDR, src1=TEMP_DIR_ADDR.
    - COMMIT: src1=TEMP_DIR_ADDR.
  - WB: if there is an error, we=0 and go to RESP. Otherwise we=1 and:
    - LOAD: dst=TEMP_ADDR, data=INIT board.
    - MOVE: dst=TEMP_ADDR, data=new board.
    - COMMIT: dst=DIRECTION_ADDR, data=history; skips WD.
  - WD: we=1, dst=TEMP_DIR_ADDR.
    - LOAD: data=0.
    - MOVE: data=history with slot d set to cmd_dir and depth d+1.
  - RESP: rsp_valid=1, with rsp_solved=comp and rsp_depth. Held until rsp_ready; then go to IDLE.
- Latency: accept in cycle 0; READ in 1; WB in 2; WD in 3; rsp_valid first in cycle 4 (cycle 3 for COMMIT and error cases).
- The register file reads combinationally. comp in RESP reflects the write from WB.
- MOVE targets:
  - up: p-3, legal if p≥3
  - down: p+3, legal if p≤5
  - left: p-1, legal if p mod 3≠0
  - right: p+1, legal if p mod 3≠2
- New board: cell p takes the old cell t value, cell t becomes 0, [39:36]=t.
- MOVE errors, checked in this priority:
  - p>8 → 11
  - d≥MAX_DEPTH → 10
  - illegal direction → 01
  - On any error, no write occurs.
- LOAD with INIT p>8 → 11, no writes.
- Reserved op → 11, no writes.
- COMMIT always succeeds; rsp_depth = history depth.
- we is never asserted outside WB/WD. Each accepted command produces exactly one response.

Optional Feature:
- Macro NO_BACKTRACK_EN.
- Defined: a MOVE where d>0 and cmd_dir is the reverse of slot d-1 is rejected with 11 and no writes. Priority is after 10 and before 01. Reverse pairs are up↔down and left↔right.
- Undefined: reversals are legal.

Test Plan:
- LOAD, start board 40'h0052143786 → TEMP=40'h0052143786, TEMP_DIR=0, rsp_err=00, rsp_depth=0, rsp_solved=0; rsp_valid in cycle 4.
- After LOAD, MOVE right → TEMP=40'h1502143786, TEMP_DIR=34'h040000003, rsp_depth=1.
- After LOAD, MOVE up → rsp_err=01; no we pulse; TEMP unchanged; rsp_valid in cycle 3.
- After LOAD:
  - MOVEs down, right, up, right, down, down → final TEMP=40'h8123456780, rsp_solved=1, rsp_depth=6.
  - Then COMMIT → DIRECTION=34'h1800005CD.
- Depth full and backtrack:
  - 15 legal alternating left/right moves → all ok. 16th MOVE → rsp_err=10.
  - With NO_BACKTRACK_EN defined, right then left → rsp_err=11.
- rsp_ready held low for 5 cycles → rsp_valid and outputs stable, cmd_ready=0. Then rst_n asserted during WD → we=0 immediately; cmd_ready=1 after release.
